// File: rtl/lb_arbiter.sv
// lb_arbiter: round-robin arbiter sharing one local bus between masters A and B.
// Define LB_ARB_LOCK_EN to add a_lock/b_lock for bounded back-to-back locked grants.
module lb_arbiter #(
  parameter int AW       = 24,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
`ifdef LB_ARB_LOCK_EN
  input  logic          a_lock,
  input  logic          b_lock,
`endif
  output logic [AW-1:0] lb_addr,
  output logic [DW-1:0] lb_wdata,
  output logic          lb_wstb,
  output logic          lb_rstb,
  input  logic [DW-1:0] lb_rdata,
  output logic          gnt,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, CAP} state_t;

  state_t        state_reg, state_next;
  logic          gnt_reg, gnt_next, last_reg, last_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic          wstb_reg, wstb_next, rstb_reg, rstb_next;
  logic          a_ack_reg, a_ack_next, b_ack_reg, b_ack_next;
  logic [DW-1:0] a_rdata_reg, a_rdata_next, b_rdata_reg, b_rdata_next;
  logic [3:0]    wait_reg, wait_next;
  logic          req_a, req_b, lock_hold, pick_valid, pick_b, pick_we;

  generate
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
      $error("lb_arbiter: RD_LAT must be within 1..15");
    end
    if (MAX_LOCK < 1 || MAX_LOCK > 255) begin : g_bad_max_lock
      $error("lb_arbiter: MAX_LOCK must be within 1..255");
    end
  endgenerate

`ifdef LB_ARB_LOCK_EN
  logic [7:0] lock_cnt_reg, lock_cnt_next, lock_cnt_eff;
  logic       owner_req;

  // A read acks in IDLE, so the count is folded in combinationally on any ack cycle.
  always_comb begin
    lock_cnt_eff = lock_cnt_reg;
    if (a_ack_reg || b_ack_reg) begin
      if (gnt_reg ? b_lock : a_lock)
        lock_cnt_eff = (lock_cnt_reg == 8'hFF) ? lock_cnt_reg : lock_cnt_reg + 8'd1;
      else
        lock_cnt_eff = 8'd0;
    end
    owner_req = gnt_reg ? b_req : a_req;
    lock_hold = (lock_cnt_eff != 8'd0) && (lock_cnt_eff < 8'(MAX_LOCK)) && owner_req;
  end

  always_comb begin
    lock_cnt_next = lock_cnt_eff;
    if (state_reg == IDLE) begin
      if (!owner_req)
        lock_cnt_next = 8'd0;
      else if (pick_valid && !lock_hold)
        lock_cnt_next = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lock_cnt_reg <= 8'd0;
    else     lock_cnt_reg <= lock_cnt_next;
  end
`else
  assign lock_hold = 1'b0;
`endif

  // A master's req is ignored during its own ack cycle so a held req is not re-served.
  always_comb begin
    req_a      = a_req & ~a_ack_reg;
    req_b      = b_req & ~b_ack_reg;
    pick_valid = 1'b0;
    pick_b     = 1'b0;
    if (lock_hold) begin
      pick_b     = gnt_reg;
      pick_valid = gnt_reg ? req_b : req_a;
    end else if (req_a && req_b) begin
      pick_valid = 1'b1;
      pick_b     = ~last_reg;
    end else if (req_a) begin
      pick_valid = 1'b1;
    end else if (req_b) begin
      pick_valid = 1'b1;
      pick_b     = 1'b1;
    end
    pick_we = pick_b ? b_we : a_we;
  end

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    last_next    = last_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstb_next    = 1'b0;
    rstb_next    = 1'b0;
    a_ack_next   = 1'b0;
    b_ack_next   = 1'b0;
    a_rdata_next = a_rdata_reg;
    b_rdata_next = b_rdata_reg;
    wait_next    = wait_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          gnt_next   = pick_b;
          last_next  = pick_b;
          addr_next  = pick_b ? b_addr : a_addr;
          wdata_next = pick_b ? b_wdata : a_wdata;
          if (pick_we) begin
            state_next = WR;
            wstb_next  = 1'b1;
            a_ack_next = ~pick_b;
            b_ack_next = pick_b;
          end else begin
            state_next = RD;
            rstb_next  = 1'b1;
          end
        end
      end
      WR: state_next = IDLE;
      RD: begin
        if (RD_LAT > 1) begin
          state_next = WAIT;
          wait_next  = 4'(RD_LAT - 2);
        end else begin
          state_next = CAP;
        end
      end
      WAIT: begin
        if (wait_reg == 4'd0) state_next = CAP;
        else                  wait_next  = wait_reg - 4'd1;
      end
      CAP: begin
        state_next = IDLE;
        if (gnt_reg) begin
          b_rdata_next = lb_rdata;
          b_ack_next   = 1'b1;
        end else begin
          a_rdata_next = lb_rdata;
          a_ack_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= 1'b0;
      last_reg    <= 1'b1;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstb_reg    <= 1'b0;
      rstb_reg    <= 1'b0;
      a_ack_reg   <= 1'b0;
      b_ack_reg   <= 1'b0;
      a_rdata_reg <= '0;
      b_rdata_reg <= '0;
      wait_reg    <= 4'd0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      last_reg    <= last_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wstb_reg    <= wstb_next;
      rstb_reg    <= rstb_next;
      a_ack_reg   <= a_ack_next;
      b_ack_reg   <= b_ack_next;
      a_rdata_reg <= a_rdata_next;
      b_rdata_reg <= b_rdata_next;
      wait_reg    <= wait_next;
    end
  end

  assign a_ack    = a_ack_reg;
  assign b_ack    = b_ack_reg;
  assign a_rdata  = a_rdata_reg;
  assign b_rdata  = b_rdata_reg;
  assign lb_addr  = addr_reg;
  assign lb_wdata = wdata_reg;
  assign lb_wstb  = wstb_reg;
  assign lb_rstb  = rstb_reg;
  assign gnt      = gnt_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_lb_arbiter.sv
// Directed bench for lb_arbiter: instance 0 uses RD_LAT=3, instances 1..3 sweep RD_LAT 1/2/15.
// Lock sequences are exercised only when LB_ARB_LOCK_EN is defined.
module tb_lb_arbiter;
  localparam int NI = 4;

  logic        clk;
  logic        rst;
  logic        a_req [NI], a_we [NI], b_req [NI], b_we [NI];
  logic [23:0] a_addr [NI], b_addr [NI];
  logic [31:0] a_wdata [NI], b_wdata [NI];
  logic        a_ack [NI], b_ack [NI];
  logic [31:0] a_rdata [NI], b_rdata [NI];
  logic [23:0] lb_addr [NI];
  logic [31:0] lb_wdata [NI], lb_rdata [NI];
  logic        lb_wstb [NI], lb_rstb [NI], gnt [NI], busy [NI];
`ifdef LB_ARB_LOCK_EN
  logic        a_lock [NI], b_lock [NI];
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat;
  logic [31:0] rd;
  logic [23:0] ad;
  bit          seen;

  function automatic logic [31:0] model_word(input logic [23:0] a);
    if (a == 24'h000001) return 32'hbeefca5e;
    return {a[7:0], ~a};
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 3 : (i == 1) ? 1 : (i == 2) ? 2 : 15;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 3 : (gi == 1) ? 1 : (gi == 2) ? 2 : 15;
      logic [31:0] pipe [LAT];

      // Downstream read model: data appears RD_LAT cycles after the strobe cycle.
      always @(posedge clk) begin
        pipe[0] <= lb_rstb[gi] ? model_word(lb_addr[gi]) : 32'hBAD0BAD0;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign lb_rdata[gi] = pipe[LAT-1];

      lb_arbiter #(.AW(24), .DW(32), .RD_LAT(LAT), .MAX_LOCK(3)) u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req[gi]), .a_we(a_we[gi]), .a_addr(a_addr[gi]), .a_wdata(a_wdata[gi]),
        .a_ack(a_ack[gi]), .a_rdata(a_rdata[gi]),
        .b_req(b_req[gi]), .b_we(b_we[gi]), .b_addr(b_addr[gi]), .b_wdata(b_wdata[gi]),
        .b_ack(b_ack[gi]), .b_rdata(b_rdata[gi]),
`ifdef LB_ARB_LOCK_EN
        .a_lock(a_lock[gi]), .b_lock(b_lock[gi]),
`endif
        .lb_addr(lb_addr[gi]), .lb_wdata(lb_wdata[gi]), .lb_wstb(lb_wstb[gi]),
        .lb_rstb(lb_rstb[gi]), .lb_rdata(lb_rdata[gi]), .gnt(gnt[gi]), .busy(busy[gi])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ctl"}, {a_ack[0], b_ack[0], lb_wstb[0], lb_rstb[0], gnt[0], busy[0]}, 64'd0);
    chk({tag, "_addr"}, lb_addr[0], 64'd0);
    chk({tag, "_wdata"}, lb_wdata[0], 64'd0);
    chk({tag, "_rdata"}, {a_rdata[0], b_rdata[0]}, 64'd0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NI; i++) begin
      a_req[i] = 1'b0;
      b_req[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One handshake on instance i by master m (0=A, 1=B); latency counted from req raise.
  task automatic txn(input int i, input bit m, input bit we, input logic [23:0] a,
                     input logic [31:0] wd, output int l, output logic [31:0] r);
    bit got, other;
    got = 1'b0; other = 1'b0; l = 0; r = '0;
    @(negedge clk);
    if (!m) begin
      a_req[i] = 1'b1; a_we[i] = we; a_addr[i] = a; a_wdata[i] = wd;
    end else begin
      b_req[i] = 1'b1; b_we[i] = we; b_addr[i] = a; b_wdata[i] = wd;
    end
    while (!got && l < 40) begin
      @(negedge clk);
      l++;
      if (m ? b_ack[i] : a_ack[i]) begin
        got = 1'b1;
        r = m ? b_rdata[i] : a_rdata[i];
      end
      if (m ? a_ack[i] : b_ack[i]) other = 1'b1;
    end
    if (!m) a_req[i] = 1'b0;
    else    b_req[i] = 1'b0;
    $display("txn inst=%0d master=%s we=%0d addr=%h latency=%0d rdata=%h",
             i, m ? "B" : "A", we, a, l, r);
    chk("txn_ack_seen", got, 1);
    chk("txn_other_ack", other, 0);
  endtask

  // Both masters hold write requests; bit k of pat is the expected k-th winner (1=B).
  task automatic run_both(input int n, input logic [15:0] pat);
    int k, cyc;
    bit both;
    k = 0; cyc = 0; both = 1'b0;
    @(negedge clk);
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 24'h000100; a_wdata[0] = 32'h0000_00aa;
    b_req[0] = 1'b1; b_we[0] = 1'b1; b_addr[0] = 24'h000200; b_wdata[0] = 32'h0000_00bb;
    while (k < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (a_ack[0] && b_ack[0]) both = 1'b1;
      if (a_ack[0] || b_ack[0]) begin
        $display("txn arb #%0d winner=%s gnt=%0d lb_addr=%h", k, b_ack[0] ? "B" : "A",
                 gnt[0], lb_addr[0]);
        chk("arb_winner", b_ack[0], pat[k]);
        chk("arb_gnt", gnt[0], pat[k]);
        k++;
      end
    end
    a_req[0] = 1'b0;
    b_req[0] = 1'b0;
    chk("arb_count", k, n);
    chk("arb_both_ack", both, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      a_req[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wdata[i] = '0;
      b_req[i] = 1'b0; b_we[i] = 1'b0; b_addr[i] = '0; b_wdata[i] = '0;
`ifdef LB_ARB_LOCK_EN
      a_lock[i] = 1'b0; b_lock[i] = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;

    // Single A write: strobe, ack and busy all in the one cycle after the request.
    @(negedge clk);
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 24'h000010; a_wdata[0] = 32'hdeadbeef;
    @(negedge clk);
    $display("txn wr inst=0 A addr=%h wdata=%h wstb=%0d ack=%0d", lb_addr[0], lb_wdata[0],
             lb_wstb[0], a_ack[0]);
    chk("wr_wstb", lb_wstb[0], 1);
    chk("wr_rstb", lb_rstb[0], 0);
    chk("wr_addr", lb_addr[0], 24'h000010);
    chk("wr_wdata", lb_wdata[0], 32'hdeadbeef);
    chk("wr_ack", {a_ack[0], b_ack[0]}, 2'b10);
    chk("wr_gnt", gnt[0], 0);
    chk("wr_busy", busy[0], 1);
    a_req[0] = 1'b0; a_addr[0] = 24'h0; a_wdata[0] = 32'h0;
    @(negedge clk);
    chk("wr_after_ctl", {lb_wstb[0], a_ack[0], busy[0]}, 3'b000);
    chk("wr_hold_addr", lb_addr[0], 24'h000010);
    chk("wr_hold_wdata", lb_wdata[0], 32'hdeadbeef);

    // A read with RD_LAT=3.
    txn(0, 1'b0, 1'b0, 24'h000001, 32'h0, lat, rd);
    chk("rd_latency", lat, 5);
    chk("rd_data", rd, 32'hbeefca5e);
    @(negedge clk);
    chk("rd_data_held", a_rdata[0], 32'hbeefca5e);
    chk("rd_ack_single", a_ack[0], 0);

    // Round-robin under continuous contention, A first after reset.
    do_reset();
    run_both(8, 16'h00AA);

    // Reset during the WAIT phase of a B read.
    @(negedge clk);
    b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 24'h000022;
    @(negedge clk);
    chk("rst_rd_rstb", lb_rstb[0], 1);
    chk("rst_rd_gnt", gnt[0], 1);
    @(negedge clk);
    chk("rst_wait_ctl", {lb_rstb[0], busy[0]}, 2'b01);
    chk("rst_wait_addr", lb_addr[0], 24'h000022);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_zero("rst_abort");
    rst = 1'b0;
    b_req[0] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (b_ack[0]) seen = 1'b1;
    end
    chk("rst_no_b_ack", seen, 0);
    txn(0, 1'b0, 1'b1, 24'h000040, 32'h12345678, lat, rd);
    chk("rst_then_wr_lat", lat, 1);
    chk("rst_then_wr_gnt", gnt[0], 0);

    // Read latency sweep on the RD_LAT 1/2/15 instances, alternating masters.
    for (int i = 1; i < NI; i++) begin
      for (int r = 0; r < 3; r++) begin
        ad = 24'h000030 + 24'(r) + 24'(i * 16);
        txn(i, r[0], 1'b0, ad, 32'h0, lat, rd);
        chk("sweep_latency", lat, lat_of(i) + 2);
        chk("sweep_rdata", rd, model_word(ad));
      end
    end

`ifdef LB_ARB_LOCK_EN
    // Locked A: three consecutive grants, then B gets a turn.
    do_reset();
    a_lock[0] = 1'b1;
    run_both(5, 16'h0008);
    do_reset();
    a_lock[0] = 1'b0;
    run_both(4, 16'h000A);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
